dsc_core_sched: RTL and testbench

Job sequencer for the DSC `core` datapath. It accepts operand sets over a valid/ready request port and drives the core's `rst`/`en` through one operation per job. An operation ends on the core's `op_finished` or on an optional per-job cycle budget, which gives early termination for accuracy/latency trade-off. The sequencer returns the result, the cycle count and a truncation flag over a valid/ready response port, and keeps running statistics. It sits between the system-level job source and one `core` instance.

---
 rtl/dsc_core_sched.sv | 91 +++++++++
 tb/tb_dsc_core_sched.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dsc_core_sched.sv
// dsc_core_sched: job sequencer that drives one DSC core through a single operation per job.
// Ports:
//   gclk, rst                          clock, synchronous active-high reset
//   req_valid/req_ready/req_operands   job request handshake and operand set
//   req_budget                         max RUN cycles for the job, 0 = unlimited
//   core_rst/core_en/core_data_in      control and registered operands to the core
//   core_op_finished/core_data_out     completion strobe and result from the core
//   rsp_valid/rsp_ready                response handshake
//   rsp_data/rsp_cycles/rsp_truncated  captured result, RUN cycles used, ended-by-budget flag
//   stat_jobs/stat_trunc               saturating counts of completed and truncated responses
module dsc_core_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_INPUTS = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                             gclk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] req_operands,
    input  logic [CNT_WIDTH-1:0]             req_budget,
    output logic                             core_rst,
    output logic                             core_en,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] core_data_in,
    input  logic                             core_op_finished,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] core_data_out,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] rsp_data,
    output logic [CNT_WIDTH-1:0]             rsp_cycles,
    output logic                             rsp_truncated,
    output logic [CNT_WIDTH-1:0]             stat_jobs,
    output logic [CNT_WIDTH-1:0]             stat_trunc
);
    typedef enum logic [1:0] {IDLE, CLEAR, RUN, RESP} state_t;
    state_t state, state_nxt;
    logic [CNT_WIDTH-1:0] budget, run_cnt, n;
    logic hit_budget, done;
    always_comb begin
        n          = &run_cnt ? run_cnt : run_cnt + 1'b1;
        hit_budget = budget != '0 && n == budget;
        done       = core_op_finished || hit_budget;
        req_ready  = state == IDLE;
        core_rst   = state != RUN;
        core_en    = state == RUN;
        rsp_valid  = state == RESP;
        state_nxt  = state == IDLE  ? (req_valid ? CLEAR : IDLE) :
                     state == CLEAR ? RUN :
                     state == RUN   ? (done ? RESP : RUN) :
                                      (rsp_ready ? IDLE : RESP);
    end
    always_ff @(posedge gclk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    always_ff @(posedge gclk) begin
        if (rst) begin
            core_data_in  <= '0;
            budget        <= '0;
            run_cnt       <= '0;
            rsp_data      <= '0;
            rsp_cycles    <= '0;
            rsp_truncated <= 1'b0;
            stat_jobs     <= '0;
            stat_trunc    <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                core_data_in <= req_operands;
                budget       <= req_budget;
            end
            if (state == CLEAR)
                run_cnt <= '0;
            if (state == RUN) begin
                run_cnt <= n;
                if (done) begin
                    rsp_data      <= core_data_out;
                    rsp_cycles    <= n;
                    // a finish in the same cycle as the budget hit is a natural finish
                    rsp_truncated <= !core_op_finished;
                end
            end
            if (state == RESP && rsp_ready) begin
                stat_jobs <= &stat_jobs ? stat_jobs : stat_jobs + 1'b1;
                if (rsp_truncated && !(&stat_trunc))
                    stat_trunc <= stat_trunc + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dsc_core_sched.sv
// tb_dsc_core_sched: directed bench for dsc_core_sched with a timeline model and a simple core model.
module tb_dsc_core_sched;
    logic gclk = 1'b0, rst = 1'b1, req_valid = 1'b0, rsp_ready = 1'b1;
    logic [31:0] req_operands = '0, req_budget = '0;
    logic req_ready, core_rst, core_en, core_op_finished, rsp_valid, rsp_truncated;
    logic [31:0] core_data_in, core_data_out, rsp_data, rsp_cycles, stat_jobs, stat_trunc;
    int checks = 0, errors = 0;
    logic [31:0] cur_fin = '0, cur_res = '0, en_cnt = '0, en_total = '0, en_start = '0;
    logic m_idle = 1'b1, m_ntr = 1'b0, m_rtr = 1'b0;
    logic [31:0] m_t = '0, m_n = '0, m_fin = '0, m_res = '0, m_ops = '0;
    logic [31:0] m_rdata = '0, m_rcyc = '0, m_jobs = '0, m_trunc = '0;

    always #5 gclk = ~gclk;

    dsc_core_sched dut (
        .gclk(gclk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_operands(req_operands), .req_budget(req_budget),
        .core_rst(core_rst), .core_en(core_en), .core_data_in(core_data_in),
        .core_op_finished(core_op_finished), .core_data_out(core_data_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_cycles(rsp_cycles), .rsp_truncated(rsp_truncated),
        .stat_jobs(stat_jobs), .stat_trunc(stat_trunc)
    );

    // core model: finishes on its m_fin-th enabled cycle; otherwise shows a cycle-tagged value
    assign core_op_finished = core_en && (en_cnt + 1 == m_fin);
    assign core_data_out = (en_cnt + 1 == m_fin) ? m_res : (32'hA500_0000 | (en_cnt + 1));

    always @(posedge gclk) begin
        en_cnt <= core_rst ? '0 : core_en ? en_cnt + 1 : en_cnt;
        if (core_en)
            en_total <= en_total + 1;
    end

    // a job lasts min(finish, budget) RUN cycles, budget 0 meaning no limit
    function automatic logic fin_first(input logic [31:0] fin, bud);
        return fin != 0 && (bud == 0 || fin <= bud);
    endfunction

    // timeline model: m_t counts cycles since accept; 1 = clear, 2..N+1 = run, N+2 = response
    always @(posedge gclk) begin
        if (rst) begin
            m_idle <= 1'b1; m_t <= '0; m_ops <= '0;
            m_rdata <= '0; m_rcyc <= '0; m_rtr <= 1'b0; m_jobs <= '0; m_trunc <= '0;
        end else if (m_idle) begin
            if (req_valid) begin
                m_idle <= 1'b0; m_t <= 1; m_ops <= req_operands;
                m_fin <= cur_fin; m_res <= cur_res;
                m_n   <= fin_first(cur_fin, req_budget) ? cur_fin : req_budget;
                m_ntr <= !fin_first(cur_fin, req_budget);
            end
        end else if (m_t < m_n + 1) begin
            m_t <= m_t + 1;
        end else if (m_t == m_n + 1) begin
            m_t <= m_t + 1;
            m_rdata <= m_ntr ? (32'hA500_0000 | m_n) : m_res;
            m_rcyc <= m_n;
            m_rtr <= m_ntr;
        end else if (rsp_ready) begin
            m_idle <= 1'b1;
            m_jobs <= m_jobs + 1;
            if (m_rtr)
                m_trunc <= m_trunc + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare;
        logic run, resp;
        run  = !m_idle && m_t >= 2 && m_t <= m_n + 1;
        resp = !m_idle && m_t == m_n + 2;
        chk("req_ready", {31'b0, req_ready}, {31'b0, m_idle});
        chk("core_rst", {31'b0, core_rst}, {31'b0, !run});
        chk("core_en", {31'b0, core_en}, {31'b0, run});
        chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, resp});
        chk("core_data_in", core_data_in, m_ops);
        chk("rsp_data", rsp_data, m_rdata);
        chk("rsp_cycles", rsp_cycles, m_rcyc);
        chk("rsp_truncated", {31'b0, rsp_truncated}, {31'b0, m_rtr});
        chk("stat_jobs", stat_jobs, m_jobs);
        chk("stat_trunc", stat_trunc, m_trunc);
    endtask

    task automatic tick;
        @(negedge gclk);
        compare();
    endtask

    task automatic wait_accept;
        for (int i = 0; i < 100 && m_idle; i++)
            tick();
        chk("accept_bound", {31'b0, m_idle}, 32'd0);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp;
        for (int i = 0; i < 200 && !(!m_idle && m_t == m_n + 2); i++)
            tick();
        chk("resp_bound", {31'b0, !m_idle && m_t == m_n + 2}, 32'd1);
    endtask

    task automatic run_job(input logic [31:0] ops, bud, fin, res);
        req_operands = ops; req_budget = bud; cur_fin = fin; cur_res = res;
        req_valid = 1'b1;
        en_start = en_total;
        wait_accept();
        wait_resp();
    endtask

    initial begin
        tick();
        tick();
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_core_rst", {31'b0, core_rst}, 32'd1);
        chk("rst_core_en", {31'b0, core_en}, 32'd0);
        chk("rst_stat_jobs", stat_jobs, 32'd0);
        chk("rst_stat_trunc", stat_trunc, 32'd0);
        rst = 1'b0;
        // reset during RUN cycle 3
        req_operands = 32'h0403_0201; req_budget = 0; cur_fin = 50; cur_res = 1;
        req_valid = 1'b1;
        wait_accept();
        for (int i = 0; i < 10 && m_t != 4; i++)
            tick();
        chk("midrst_running", {31'b0, core_en}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_core_en", {31'b0, core_en}, 32'd0);
        chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("midrst_stat_jobs", stat_jobs, 32'd0);
        // natural finish
        run_job(32'h0907_0503, 0, 7, 945);
        chk("nat_data", rsp_data, 32'd945);
        chk("nat_cycles", rsp_cycles, 32'd7);
        chk("nat_trunc", {31'b0, rsp_truncated}, 32'd0);
        chk("nat_en_cycles", en_total - en_start, 32'd7);
        tick();
        chk("nat_stat_jobs", stat_jobs, 32'd1);
        // budget truncation
        run_job(32'h1122_3344, 5, 20, 1234);
        chk("trunc_cycles", rsp_cycles, 32'd5);
        chk("trunc_flag", {31'b0, rsp_truncated}, 32'd1);
        chk("trunc_data", rsp_data, 32'hA500_0005);
        chk("trunc_en_cycles", en_total - en_start, 32'd5);
        tick();
        chk("trunc_stat_trunc", stat_trunc, 32'd1);
        chk("trunc_stat_jobs", stat_jobs, 32'd2);
        // finish and budget in the same cycle
        run_job(32'hAABB_CCDD, 4, 4, 77);
        chk("simul_cycles", rsp_cycles, 32'd4);
        chk("simul_trunc", {31'b0, rsp_truncated}, 32'd0);
        chk("simul_data", rsp_data, 32'd77);
        tick();
        // budget 1: minimum latency
        run_job(32'h0101_0101, 1, 0, 0);
        chk("b1_cycles", rsp_cycles, 32'd1);
        chk("b1_trunc", {31'b0, rsp_truncated}, 32'd1);
        chk("b1_en_cycles", en_total - en_start, 32'd1);
        tick();
        // backpressure with a pending request
        rsp_ready = 1'b0;
        run_job(32'hDEAD_BEEF, 0, 2, 32'h0000_BEEF);
        req_operands = 32'h5566_7788; req_budget = 3; cur_fin = 9; cur_res = 5;
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_data", rsp_data, 32'h0000_BEEF);
            chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
            chk("bp_core_en", {31'b0, core_en}, 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_release_ready", {31'b0, req_ready}, 32'd1);
        chk("bp_stat_jobs", stat_jobs, 32'd5);
        chk("bp_stat_trunc", stat_trunc, 32'd2);
        tick();
        chk("bp_next_ops", core_data_in, 32'h5566_7788);
        chk("bp_next_clear", {31'b0, core_rst}, 32'd1);
        req_valid = 1'b0;
        wait_resp();
        chk("bp_next_cycles", rsp_cycles, 32'd3);
        chk("bp_next_trunc", {31'b0, rsp_truncated}, 32'd1);
        tick();
        chk("end_stat_jobs", stat_jobs, 32'd6);
        chk("end_stat_trunc", stat_trunc, 32'd3);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
